// File: rtl/c_dly_coarse_ctrl.sv
// Coarse delay-line tap controller: filters phase-detector votes into saturating code steps.
// Optional lock detection compiled in with DLY_COARSE_LOCK_EN.
module c_dly_coarse_ctrl #(
   parameter int P_FILT_TH   = 4,
   parameter int P_SETTLE    = 3,
   parameter int P_INIT_CODE = 0,
   parameter int P_LOCK_CNT  = 4
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_en,
   input  logic       i_up,
   input  logic       i_dn,
   output logic [7:0] o_sel,
   output logic [2:0] o_code,
   output logic       o_lock,
   output logic       o_ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRACK,
      S_LOCK
   } state_t;

   localparam logic signed [4:0] TH_P = 5'(P_FILT_TH);
   localparam logic signed [4:0] TH_N = -TH_P;
   localparam logic [3:0] SETTLE = 4'(P_SETTLE);
   localparam logic [2:0] INIT = 3'(P_INIT_CODE);
   localparam logic [7:0] SEL0 = 8'b1 << INIT;

   state_t            state;
   logic signed [4:0] acc;
   logic signed [4:0] acc_nx;
   logic [3:0]        blank;
   logic              active;
   logic              inc_req;
   logic              dec_req;
   logic              sat;
   logic              move;

   always_comb begin
      active = i_en && (state != S_IDLE) && (blank == 4'd0);
      acc_nx = acc;
      if (i_up && !i_dn)
         acc_nx = acc + 5'sd1;
      else if (i_dn && !i_up)
         acc_nx = acc - 5'sd1;
      inc_req = active && (acc_nx == TH_P);
      dec_req = active && (acc_nx == TH_N);
      sat = (inc_req && o_code == 3'd7) ||
            (dec_req && o_code == 3'd0);
      move = (inc_req || dec_req) && !sat;
   end

`ifdef DLY_COARSE_LOCK_EN
   typedef enum logic [1:0] {
      D_NONE,
      D_UP,
      D_DN
   } dir_t;

   localparam logic [3:0] LOCK_N = 4'(P_LOCK_CNT);

   dir_t       last;
   dir_t       dir_nx;
   logic [3:0] rev;
   logic [3:0] rev_nx;
   logic       rev_ev;
   logic       same_ev;

   always_comb begin
      dir_nx  = inc_req ? D_UP : D_DN;
      rev_ev  = move && (last != D_NONE) && (last != dir_nx);
      same_ev = move && (last == dir_nx);
      rev_nx  = rev;
      if (same_ev)
         rev_nx = 4'd0;
      else if (rev_ev && rev != 4'hF)
         rev_nx = rev + 4'd1;
   end
`else
   assign o_lock = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state  <= S_IDLE;
         o_code <= INIT;
         o_sel  <= SEL0;
         acc    <= '0;
         blank  <= '0;
         o_ovf  <= 1'b0;
`ifdef DLY_COARSE_LOCK_EN
         o_lock <= 1'b0;
         rev    <= '0;
         last   <= D_NONE;
`endif
      end else begin
         o_ovf <= sat;
         if (blank != 4'd0)
            blank <= blank - 4'd1;
         // o_sel shifts alongside o_code so it stays one-hot
         if (move) begin
            blank <= SETTLE;
            if (inc_req) begin
               o_code <= o_code + 3'd1;
               o_sel  <= {o_sel[6:0], 1'b0};
            end else begin
               o_code <= o_code - 3'd1;
               o_sel  <= {1'b0, o_sel[7:1]};
            end
         end
         if (!i_en) begin
            state <= S_IDLE;
            acc   <= '0;
`ifdef DLY_COARSE_LOCK_EN
            o_lock <= 1'b0;
            rev    <= '0;
`endif
         end else begin
            unique case (state)
               S_IDLE: begin
                  state <= S_TRACK;
                  acc   <= '0;
               end
               S_TRACK: begin
                  if (blank != 4'd0 || inc_req || dec_req)
                     acc <= '0;
                  else
                     acc <= acc_nx;
`ifdef DLY_COARSE_LOCK_EN
                  if (move) begin
                     rev  <= rev_nx;
                     last <= dir_nx;
                     if (rev_nx >= LOCK_N) begin
                        state  <= S_LOCK;
                        o_lock <= 1'b1;
                     end
                  end
`endif
               end
               S_LOCK: begin
                  if (blank != 4'd0 || inc_req || dec_req)
                     acc <= '0;
                  else
                     acc <= acc_nx;
`ifdef DLY_COARSE_LOCK_EN
                  if (move)
                     last <= dir_nx;
                  if (sat || same_ev) begin
                     state  <= S_TRACK;
                     o_lock <= 1'b0;
                     rev    <= '0;
                  end else if (move) begin
                     rev <= rev_nx;
                  end
`endif
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
